perceptron_trainer: RTL and testbench
=====================================

PERCEPTRON_TRAINER -- requirements
Module: perceptron_trainer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  LR  4  signed learning rate applied per error
  MAX_EPOCHS  32  epoch limit before giving up
  INIT_W0 / INIT_W1 / INIT_BIAS  0 / 0 / 0  weights loaded at each start
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  Clk  in  1  single clock, rising edge
  Reset_n  in  1  asynchronous, active-low reset
  start  in  1  request training; sampled when idle
  target  in  4  desired gate output; bit i is for sample i (x0=i[0], x1=i[1])
  w0, w1, bias  out  8 signed  current weights, for direct use by a 2-input perceptron
  busy  out  1  high while training
  done  out  1  high from training finish until the next accepted start
  converged  out  1  valid when done; 1 = last epoch had zero errors
  epoch  out  6  completed-epoch count

Function
REQ-003 FSM states SHALL be IDLE, EVAL, UPDATE, EPOCH_END and DONE.
REQ-004 Start acceptance: start=1 in IDLE or DONE SHALL capture target, load INIT_* into the weights, clear epoch, done, converged and the error count, set busy and enter EVAL with sample index 0.
REQ-005 start SHALL be ignored while busy.
REQ-006 EVAL: sum = w0*x0 + w1*x1 + bias SHALL be computed at 10-bit signed width with no overflow; y = (sum > 0) SHALL be registered; next state UPDATE.
REQ-007 UPDATE when y != t, with d = t - y (+1 or -1):
  w0 += d*LR*x0, w1 += d*LR*x1, bias += d*LR;
  each result SHALL saturate to [-128, 127];
  the error count SHALL increment.
REQ-008 UPDATE when y == t SHALL leave weights and error count unchanged.
REQ-009 UPDATE exit: sample index 0..3 SHALL advance to the next sample and return to EVAL; after sample 3 the next state SHALL be EPOCH_END.
REQ-010 Each sample SHALL take 2 cycles and each epoch 9 cycles (4 x EVAL/UPDATE + EPOCH_END).
REQ-011 EPOCH_END SHALL increment epoch.
  - If the error count is 0: go to DONE with converged=1.
  - Else if epoch+1 == MAX_EPOCHS: go to DONE with converged=0.
  - Else: clear the error count and return to EVAL at sample 0.
REQ-012 DONE SHALL hold busy=0, done=1, and hold the weights and epoch stable until the next accepted start.
REQ-013 done SHALL first be high exactly 9*epoch cycles after the start-accept edge.
REQ-014 Weight outputs SHALL be registered and SHALL change only on UPDATE edges or at start acceptance.

Reset
REQ-015 Reset_n low SHALL asynchronously force: state IDLE; busy=0, done=0, converged=0; epoch=0; w0/w1/bias = INIT_*; sample index and error count = 0.
REQ-016 Reset mid-training SHALL abandon the run; the next start SHALL retrain from INIT_* with a result identical to a clean run.

Structure
REQ-017 Shared package nn_pkg SHALL hold:
  - state enum;
  - WEIGHT_W=8, SUM_W=10, NUM_SAMPLES=4;
  - a saturating-add function.
REQ-018 Combinational sub-module perceptron_eval (inputs x0, x1, w0, w1, bias; outputs sum and y) SHALL implement the forward step so the trainer and the inference bench share identical arithmetic.

Verification
REQ-019 Defaults, target=4'b1000 (AND) -> done after 54 cycles; converged=1, epoch=6, w0=4, w1=8, bias=-8; all four inputs classify correctly.
REQ-020 target=4'b0000 -> converged=1, epoch=1, weights 0/0/0, done after 9 cycles.
REQ-021 target=4'b0110 (XOR) -> converged=0, epoch=32, done after 288 cycles.
REQ-022 Saturation:
  - Stimulus: INIT_W0=120, INIT_BIAS=-127, LR=16, target=4'b0010.
  - After the sample-1 UPDATE: w0=127 (saturated), bias=-111, w1=0.
REQ-023 start pulsed while busy is ignored; after DONE, a new start with target=4'b1110 (OR) restarts from INIT_* and converges.
REQ-024 Reset_n low during epoch 3 of AND training -> all outputs at reset values immediately; a following start reproduces REQ-019 exactly.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared types, widths and saturating arithmetic for the perceptron trainer and its inference users.
package nn_pkg;

  localparam int unsigned WEIGHT_W    = 8;
  localparam int unsigned SUM_W       = 10;
  localparam int unsigned NUM_SAMPLES = 4;
  localparam int unsigned IDX_W       = 2;
  localparam int unsigned EPOCH_W     = 6;
  localparam int unsigned ERR_W       = 3;
  localparam int unsigned ACC_W       = SUM_W + 1;

  localparam int W_MAX = 127;
  localparam int W_MIN = -128;

  typedef enum logic [2:0] {
    IDLE,
    EVAL,
    UPDATE,
    EPOCH_END,
    DONE
  } state_e;

  // Adds a signed step to a weight and clamps the result to the weight range.
  function automatic logic signed [WEIGHT_W-1:0] sat_add(
    input logic signed [WEIGHT_W-1:0] a,
    input logic signed [SUM_W-1:0]    b
  );
    logic signed [ACC_W-1:0] s;
    s = ACC_W'(a) + ACC_W'(b);
    if (s > ACC_W'(W_MAX)) begin
      return WEIGHT_W'(W_MAX);
    end else if (s < ACC_W'(W_MIN)) begin
      return WEIGHT_W'(W_MIN);
    end else begin
      return WEIGHT_W'(s);
    end
  endfunction

endpackage

// File: rtl/perceptron_eval.sv
// Combinational forward step of a 2-input perceptron: sum = w0*x0 + w1*x1 + bias, y = (sum > 0).
module perceptron_eval
  import nn_pkg::*;
(
  input  logic                       x0,
  input  logic                       x1,
  input  logic signed [WEIGHT_W-1:0] w0,
  input  logic signed [WEIGHT_W-1:0] w1,
  input  logic signed [WEIGHT_W-1:0] bias,
  output logic signed [SUM_W-1:0]    sum,
  output logic                       y
);

  // Inputs are single bits, so multiplication reduces to conditional adds.
  always_comb begin
    sum = SUM_W'(bias);
    if (x0) sum = sum + SUM_W'(w0);
    if (x1) sum = sum + SUM_W'(w1);
    y = !sum[SUM_W-1] && (sum != '0);
  end

endmodule

// File: rtl/perceptron_trainer.sv
// Trains a 2-input perceptron on a 4-entry truth table with the perceptron rule until an epoch is error-free.
module perceptron_trainer
  import nn_pkg::*;
#(
  parameter int          LR         = 4,
  parameter int unsigned MAX_EPOCHS = 32,
  parameter int          INIT_W0    = 0,
  parameter int          INIT_W1    = 0,
  parameter int          INIT_BIAS  = 0
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  input  logic                       start,
  input  logic [NUM_SAMPLES-1:0]     target,
  output logic signed [WEIGHT_W-1:0] w0,
  output logic signed [WEIGHT_W-1:0] w1,
  output logic signed [WEIGHT_W-1:0] bias,
  output logic                       busy,
  output logic                       done,
  output logic                       converged,
  output logic [EPOCH_W-1:0]         epoch
);

  state_e                     state_q, state_d;
  logic [NUM_SAMPLES-1:0]     target_q, target_d;
  logic signed [WEIGHT_W-1:0] w0_q, w0_d;
  logic signed [WEIGHT_W-1:0] w1_q, w1_d;
  logic signed [WEIGHT_W-1:0] bias_q, bias_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [ERR_W-1:0]           err_q, err_d;
  logic [EPOCH_W-1:0]         epoch_q, epoch_d;
  logic                       y_q, y_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       conv_q, conv_d;

  logic                       y_c;
  logic signed [SUM_W-1:0]    eval_sum_unused;
  logic signed [SUM_W-1:0]    step_c;

  perceptron_eval u_eval (
    .x0   (idx_q[0]),
    .x1   (idx_q[1]),
    .w0   (w0_q),
    .w1   (w1_q),
    .bias (bias_q),
    .sum  (eval_sum_unused),
    .y    (y_c)
  );

  // d = t - y is only nonzero on a misclassification, so its sign follows the target bit.
  assign step_c = target_q[idx_q] ? SUM_W'(LR) : -SUM_W'(LR);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      target_q <= '0;
      w0_q     <= WEIGHT_W'(INIT_W0);
      w1_q     <= WEIGHT_W'(INIT_W1);
      bias_q   <= WEIGHT_W'(INIT_BIAS);
      idx_q    <= '0;
      err_q    <= '0;
      epoch_q  <= '0;
      y_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      conv_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      w0_q     <= w0_d;
      w1_q     <= w1_d;
      bias_q   <= bias_d;
      idx_q    <= idx_d;
      err_q    <= err_d;
      epoch_q  <= epoch_d;
      y_q      <= y_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      conv_q   <= conv_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    w0_d     = w0_q;
    w1_d     = w1_q;
    bias_d   = bias_q;
    idx_d    = idx_q;
    err_d    = err_q;
    epoch_d  = epoch_q;
    y_d      = y_q;
    busy_d   = busy_q;
    done_d   = done_q;
    conv_d   = conv_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          target_d = target;
          w0_d     = WEIGHT_W'(INIT_W0);
          w1_d     = WEIGHT_W'(INIT_W1);
          bias_d   = WEIGHT_W'(INIT_BIAS);
          idx_d    = '0;
          err_d    = '0;
          epoch_d  = '0;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          conv_d   = 1'b0;
          state_d  = EVAL;
        end
      end
      EVAL: begin
        y_d     = y_c;
        state_d = UPDATE;
      end
      UPDATE: begin
        if (y_q != target_q[idx_q]) begin
          bias_d = sat_add(bias_q, step_c);
          if (idx_q[0]) w0_d = sat_add(w0_q, step_c);
          if (idx_q[1]) w1_d = sat_add(w1_q, step_c);
          err_d = err_q + ERR_W'(1);
        end
        // Index wraps to sample 0 after the last sample, ready for the next epoch.
        idx_d   = idx_q + IDX_W'(1);
        state_d = (idx_q == IDX_W'(NUM_SAMPLES - 1)) ? EPOCH_END : EVAL;
      end
      EPOCH_END: begin
        epoch_d = epoch_q + EPOCH_W'(1);
        if (err_q == '0) begin
          conv_d  = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end else if (epoch_d == EPOCH_W'(MAX_EPOCHS)) begin
          conv_d  = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end else begin
          err_d   = '0;
          idx_d   = '0;
          state_d = EVAL;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign w0        = w0_q;
  assign w1        = w1_q;
  assign bias      = bias_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign converged = conv_q;
  assign epoch     = epoch_q;

endmodule

// File: tb/tb_perceptron_trainer.sv
// Scoreboard bench for perceptron_trainer: expected run results are queued at start, checked when done rises.
module tb_perceptron_trainer;
  import nn_pkg::*;

  typedef struct {
    int         lat;
    int         conv;
    int         ep;
    bit         chk_w;
    int         ew0;
    int         ew1;
    int         eb;
    bit         chk_cls;
    logic [3:0] tgt;
  } exp_t;

  logic                       Clk;
  logic                       Reset_n;
  logic                       start;
  logic [3:0]                 target;
  logic signed [WEIGHT_W-1:0] w0, w1, bias;
  logic                       busy, done, converged;
  logic [EPOCH_W-1:0]         epoch;

  logic                       s_start;
  logic [3:0]                 s_target;
  logic signed [WEIGHT_W-1:0] s_w0, s_w1, s_bias;
  logic                       s_busy, s_done, s_converged;
  logic [EPOCH_W-1:0]         s_epoch;

  int   checks    = 0;
  int   errors    = 0;
  int   cyc       = 0;
  int   start_cyc = 0;
  logic done_prev = 1'b0;
  exp_t sb[$];

  logic [3:0]              y_inf;
  logic signed [SUM_W-1:0] sum_unused [4];

  perceptron_trainer u_dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .start     (start),
    .target    (target),
    .w0        (w0),
    .w1        (w1),
    .bias      (bias),
    .busy      (busy),
    .done      (done),
    .converged (converged),
    .epoch     (epoch)
  );

  perceptron_trainer #(
    .LR        (16),
    .INIT_W0   (120),
    .INIT_BIAS (-127)
  ) u_sat (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .start     (s_start),
    .target    (s_target),
    .w0        (s_w0),
    .w1        (s_w1),
    .bias      (s_bias),
    .busy      (s_busy),
    .done      (s_done),
    .converged (s_converged),
    .epoch     (s_epoch)
  );

  // Inference on all four inputs using the trained weights.
  for (genvar g = 0; g < 4; g++) begin : g_inf
    localparam logic [1:0] IDX = 2'(g);
    perceptron_eval u_inf (
      .x0   (IDX[0]),
      .x1   (IDX[1]),
      .w0   (w0),
      .w1   (w1),
      .bias (bias),
      .sum  (sum_unused[g]),
      .y    (y_inf[g])
    );
  end

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  function automatic void push(input int lat, input int conv, input int ep, input bit chk_w,
                               input int a, input int b, input int c, input bit chk_cls,
                               input logic [3:0] t);
    exp_t e;
    e.lat = lat; e.conv = conv; e.ep = ep; e.chk_w = chk_w;
    e.ew0 = a; e.ew1 = b; e.eb = c; e.chk_cls = chk_cls; e.tgt = t;
    sb.push_back(e);
  endfunction

  task automatic start_run(input logic [3:0] t);
    @(negedge Clk);
    target = t;
    start  = 1'b1;
    @(posedge Clk);
    #1;
    start_cyc = cyc;
    start     = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(negedge Clk);
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got done=0 expected done=1 within %0d cycles", budget);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_converged"}, converged, 0);
    check({tag, "_epoch"}, epoch, 0);
    check({tag, "_w0"}, w0, 0);
    check({tag, "_w1"}, w1, 0);
    check({tag, "_bias"}, bias, 0);
  endtask

  // Monitor: every rising done pops one expected run result.
  always @(negedge Clk) begin : mon
    exp_t e;
    if (done && !done_prev) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending run");
      end else begin
        e = sb.pop_front();
        check("latency", cyc - start_cyc, e.lat);
        check("converged", converged, e.conv);
        check("epoch", epoch, e.ep);
        check("busy_at_done", busy, 0);
        if (e.chk_w) begin
          check("w0", w0, e.ew0);
          check("w1", w1, e.ew1);
          check("bias", bias, e.eb);
        end
        if (e.chk_cls) begin
          for (int i = 0; i < 4; i++) check($sformatf("classify_x%0d", i), y_inf[i], e.tgt[i]);
        end
      end
    end
    done_prev = done;
  end

  initial begin : stim
    int n;
    Reset_n  = 1'b0;
    start    = 1'b0;
    target   = 4'b0000;
    s_start  = 1'b0;
    s_target = 4'b0000;
    repeat (2) @(negedge Clk);
    check_reset_state("reset");
    Reset_n = 1'b1;

    // AND, with a start pulse while busy that must be ignored
    push(54, 1, 6, 1'b1, 4, 8, -8, 1'b1, 4'b1000);
    start_run(4'b1000);
    repeat (5) @(negedge Clk);
    start  = 1'b1;
    target = 4'b0000;
    @(negedge Clk);
    start  = 1'b0;
    target = 4'b1000;
    wait_done(200);

    // OR restarted straight from DONE
    push(36, 1, 4, 1'b1, 4, 4, 0, 1'b1, 4'b1110);
    start_run(4'b1110);
    wait_done(200);

    // All-zero target converges in the first epoch
    push(9, 1, 1, 1'b1, 0, 0, 0, 1'b1, 4'b0000);
    start_run(4'b0000);
    wait_done(100);

    // XOR never converges and hits the epoch limit
    push(288, 0, 32, 1'b0, 0, 0, 0, 1'b0, 4'b0110);
    start_run(4'b0110);
    wait_done(400);

    // Reset during epoch 3 of AND, then a clean retrain
    start_run(4'b1000);
    repeat (22) @(negedge Clk);
    check("epoch_before_reset", epoch, 2);
    check("busy_before_reset", busy, 1);
    Reset_n = 1'b0;
    #1;
    check_reset_state("midrun_reset");
    @(negedge Clk);
    Reset_n = 1'b1;
    push(54, 1, 6, 1'b1, 4, 8, -8, 1'b1, 4'b1000);
    start_run(4'b1000);
    wait_done(200);

    // Saturating update on the second instance
    @(negedge Clk);
    s_target = 4'b0010;
    s_start  = 1'b1;
    @(posedge Clk);
    #1;
    s_start = 1'b0;
    repeat (4) @(posedge Clk);
    #1;
    check("sat_w0", s_w0, 127);
    check("sat_w1", s_w1, 0);
    check("sat_bias", s_bias, -111);
    n = 4;
    while (!s_done && n < 100) begin
      @(posedge Clk);
      #1;
      n++;
    end
    check("sat_latency", n, 27);
    check("sat_converged", s_converged, 1);
    check("sat_epoch", s_epoch, 3);
    check("sat_final_w0", s_w0, 127);
    check("sat_final_w1", s_w1, -16);
    check("sat_final_bias", s_bias, -111);

    repeat (2) @(negedge Clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
